// File: rtl/memctrl_pkg.sv
// Shared constants for the MEMCTRL host-side initiator: FSM encoding, idle strobe levels and
// bank field position within the 16-bit address.
package memctrl_pkg;

  // FSM encoding, kept as plain constants for compatibility with older tools.
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSetup   = 2'd1;
  localparam logic [1:0] StStrobe  = 2'd2;
  localparam logic [1:0] StRecover = 2'd3;

  // Strobe levels while no access is in flight.
  localparam logic IdleCe  = 1'b0;
  localparam logic IdleCsb = 1'b1;
  localparam logic IdleOeb = 1'b1;
  localparam logic IdleWeb = 1'b1;

  // Bank select lives in the top two address bits; bursts simply carry across it.
  localparam int unsigned BankMsb = 15;
  localparam int unsigned BankLsb = 14;

  function automatic logic [1:0] bank_of(input logic [15:0] a);
    return a[BankMsb:BankLsb];
  endfunction

endpackage

// File: rtl/memctrl_rd_hold.sv
// One-entry read-data holding register. A captured beat is presented on rd_valid/rd_data and
// held until the consumer asserts rd_ready.
module memctrl_rd_hold (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data
);

  logic       valid_q;
  logic [7:0] data_q;

  // Load on capture, drop valid once consumed; the initiator never loads while still valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else if (in_valid) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (rd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/memctrl_host_master.sv
// MEMCTRL bus initiator: accepts single/burst requests and issues one registered strobe cycle
// per beat, separated by a recovery gap. Read data is captured RD_LAT edges after the strobe
// and handed to the requester through a one-entry holding register.
module memctrl_host_master
  import memctrl_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [15:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic [15:0]      addr,
  output logic             ce,
  output logic             csb,
  output logic [7:0]       idata,
  output logic             oeb,
  output logic             web,
  input  logic [7:0]       odata
);

  // One down-counter serves both the recovery gap and the read capture point. It is loaded on
  // the strobe-asserting edge and decrements once per cycle, saturating at zero.
  localparam int unsigned    CntMax  = (GAP_CYC > RD_LAT) ? GAP_CYC : RD_LAT;
  localparam int unsigned    CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(CntMax);
  localparam logic [CntW-1:0] CapCnt  = CntW'(CntMax - RD_LAT + 1);
  localparam logic [CntW-1:0] GapCnt  = CntW'(CntMax - GAP_CYC);

  logic [1:0]       state_q, state_d;
  logic             write_q, write_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             ce_q, ce_d;
  logic             csb_q, csb_d;
  logic             oeb_q, oeb_d;
  logic             web_q, web_d;
  logic [7:0]       idata_q, idata_d;
  logic             rd_wait_q, rd_wait_d;
  logic             cap_pend_q, cap_pend_d;
  logic [7:0]       cap_q, cap_d;
  logic             gap_done, rd_done;

  // Read beats may only move on once their data sits in the holding register and has been (or
  // is being) consumed; this keeps a new capture from ever colliding with a pending one.
  assign gap_done = (cnt_q <= GapCnt);
  assign rd_done  = write_q | (~rd_wait_q & ~cap_pend_q & (~rd_valid | rd_ready));

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    beats_d    = beats_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    addr_d     = addr_q;
    ce_d       = ce_q;
    csb_d      = csb_q;
    oeb_d      = oeb_q;
    web_d      = web_q;
    idata_d    = idata_q;
    rd_wait_d  = rd_wait_q;
    cap_pend_d = 1'b0;
    cap_d      = cap_q;

    if (rd_wait_q && (cnt_q == CapCnt)) begin
      rd_wait_d  = 1'b0;
      cap_pend_d = 1'b1;
      cap_d      = odata;
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          beats_d = req_len;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (!write_q || wr_valid) begin
          state_d   = StStrobe;
          ce_d      = 1'b1;
          csb_d     = 1'b0;
          oeb_d     = write_q;
          web_d     = ~write_q;
          cnt_d     = CntLoad;
          rd_wait_d = ~write_q;
          if (write_q) begin
            idata_d = wr_data;
          end
        end
      end
      StStrobe: begin
        state_d = StRecover;
        ce_d    = IdleCe;
        csb_d   = IdleCsb;
        oeb_d   = IdleOeb;
        web_d   = IdleWeb;
        idata_d = 8'h00;
      end
      StRecover: begin
        if (gap_done && rd_done) begin
          if (beats_q != '0) begin
            beats_d = beats_q - 1'b1;
            addr_d  = addr_q + 16'd1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and MEMCTRL-side output registers; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      beats_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= 16'h0000;
      ce_q       <= IdleCe;
      csb_q      <= IdleCsb;
      oeb_q      <= IdleOeb;
      web_q      <= IdleWeb;
      idata_q    <= 8'h00;
      rd_wait_q  <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      csb_q      <= csb_d;
      oeb_q      <= oeb_d;
      web_q      <= web_d;
      idata_q    <= idata_d;
      rd_wait_q  <= rd_wait_d;
      cap_pend_q <= cap_pend_d;
      cap_q      <= cap_d;
    end
  end

  memctrl_rd_hold u_rd_hold (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (cap_pend_q),
    .in_data  (cap_q),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign wr_ready  = (state_q == StSetup) && write_q;
  assign addr      = addr_q;
  assign ce        = ce_q;
  assign csb       = csb_q;
  assign oeb       = oeb_q;
  assign web       = web_q;
  assign idata     = idata_q;

endmodule

// File: tb/tb_memctrl_host_master.sv
// Bench for memctrl_host_master: directed scenarios plus randomized bursts, checked against a
// request-level memory model and an expected strobe trace.
module tb_memctrl_host_master;

  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid, req_ready, req_write;
  logic [15:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid, wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid, rd_ready;
  logic [7:0]       rd_data;
  logic             busy;
  logic [15:0]      addr;
  logic             ce, csb, oeb, web;
  logic [7:0]       idata, odata;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [7:0]  slave_mem [65536];
  logic [7:0]  ref_mem   [65536];
  logic [24:0] obs_q [$];
  logic [24:0] exp_q [$];
  logic [7:0]  got_q [$];

  int last_strobe    = -100;
  int last_rd_strobe = -100;
  bit prev_rdv       = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memctrl_host_master #(
    .GAP_CYC (GAP_CYC),
    .RD_LAT  (RD_LAT),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .addr      (addr),
    .ce        (ce),
    .csb       (csb),
    .idata     (idata),
    .oeb       (oeb),
    .web       (web),
    .odata     (odata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // MEMCTRL device model: writes land on the strobe edge; read data is valid only in the
  // cycle ending RD_LAT (=2) edges after the strobe-asserting edge, random noise otherwise.
  always @(posedge clk) begin
    if (ce && !csb && !web) slave_mem[addr] <= idata;
    if (ce && !csb && !oeb) odata <= slave_mem[addr];
    else odata <= 8'($urandom);
  end

  // Bus protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ce) begin
        chk("strobe_csb", {31'd0, csb}, 0);
        chk("strobe_one_dir", {31'd0, oeb ^ web}, 1);
        chk("strobe_spacing", {31'd0, (cyc - last_strobe) >= int'(GAP_CYC + 1)}, 1);
        if (!oeb) begin
          chk("rd_strobe_holding_empty", {31'd0, rd_valid}, 0);
          last_rd_strobe = cyc;
        end
        obs_q.push_back({~web, addr, idata});
        last_strobe = cyc;
      end else begin
        chk("idle_strobes", {20'd0, csb, oeb, web, idata}, {20'd0, 3'b111, 8'h00});
      end
      if (rd_valid && !prev_rdv) chk("rd_latency", cyc - last_rd_strobe, RD_LAT + 1);
      chk("req_ready_vs_busy", {31'd0, req_ready}, {31'd0, ~busy});
      prev_rdv = rd_valid;
    end
  end

  task automatic cmp_strobes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 0);
  endtask

  task automatic send_req(input bit wr, input logic [15:0] a, input logic [LEN_W-1:0] len);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", {31'd0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Write burst; fixed_data >= 0 forces every beat's data, abort_beat >= 0 resets mid-strobe.
  task automatic write_burst(input logic [15:0] a, input int len, input int stall_beat,
                             input int stall_cyc, input int abort_beat, input int fixed_data);
    logic [15:0] ba;
    logic [7:0]  d;
    int          n, stall;
    obs_q.delete();
    exp_q.delete();
    send_req(1'b1, a, LEN_W'(len));
    for (int i = 0; i <= len; i++) begin
      ba    = a + 16'(i);
      d     = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom);
      stall = (i == stall_beat) ? stall_cyc : int'($urandom_range(0, 2));
      wr_valid = 1'b0;
      repeat (stall) @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      n = 0;
      while (!wr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wr_accept", {31'd0, wr_ready}, 1);
      @(posedge clk);
      ref_mem[ba] = d;
      exp_q.push_back({1'b1, ba, d});
      @(negedge clk);
      wr_valid = 1'b0;
      if (i == abort_beat) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_ce", {31'd0, ce}, 0);
        chk("abort_strobes", {29'd0, csb, oeb, web}, 3'b111);
        chk("abort_busy", {31'd0, busy}, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_restart", {31'd0, busy}, 0);
        cmp_strobes("abort_trace");
        return;
      end
    end
    wait_idle("wr_done");
    cmp_strobes("wr_trace");
  endtask

  task automatic read_burst(input logic [15:0] a, input int len, input int stall_beat,
                            input int stall_cyc);
    logic [15:0] ba;
    logic [7:0]  e;
    int          n, stall;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back({1'b0, a + 16'(i), 8'h00});
    rd_ready = 1'b0;
    send_req(1'b0, a, LEN_W'(len));
    for (int i = 0; i <= len; i++) begin
      ba = a + 16'(i);
      e  = ref_mem[ba];
      n  = 0;
      while (rd_valid !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("rd_arrive", {31'd0, rd_valid}, 1);
      stall = (i == stall_beat) ? stall_cyc : int'($urandom_range(0, 2));
      repeat (stall) begin
        chk("rd_hold_valid", {31'd0, rd_valid}, 1);
        chk("rd_hold_data", {24'd0, rd_data}, {24'd0, e});
        @(negedge clk);
      end
      chk("rd_data", {24'd0, rd_data}, {24'd0, e});
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    wait_idle("rd_done");
    chk("rd_no_extra", {31'd0, rd_valid}, 0);
    cmp_strobes("rd_trace");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] a;
    int          acc, n, len;
    logic [7:0]  t2_data [4];
    logic [15:0] t2_addr [4];

    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      slave_mem[i] = v;
      ref_mem[i]   = v;
    end
    rstn = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;

    // T1: reset values
    repeat (4) begin
      @(negedge clk);
      chk("rst_strobes", {28'd0, ce, csb, oeb, web}, 4'b0111);
      chk("rst_addr", {16'd0, addr}, 0);
      chk("rst_idata", {24'd0, idata}, 0);
      chk("rst_rd", {23'd0, rd_valid, rd_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 1);
    chk("rel_wr_ready", {31'd0, wr_ready}, 0);
    mon_en = 1'b1;

    // T2: one write per bank, then read back
    t2_data[0] = 8'hA5; t2_data[1] = 8'h3C; t2_data[2] = 8'h7E; t2_data[3] = 8'hC3;
    t2_addr[0] = 16'h0000; t2_addr[1] = 16'h4000; t2_addr[2] = 16'h8000; t2_addr[3] = 16'hC000;
    for (int i = 0; i < 4; i++) write_burst(t2_addr[i], 0, -1, 0, -1, int'(t2_data[i]));
    for (int i = 0; i < 4; i++) begin
      read_burst(t2_addr[i], 0, -1, 0);
      chk("t2_model", {24'd0, ref_mem[t2_addr[i]]}, {24'd0, t2_data[i]});
    end

    // T3: wrapping write burst with data stall before beat 2
    write_burst(16'hFFFE, 3, 2, 3, -1, -1);

    // T4: read burst with a long consumer stall on beat 0
    read_burst(16'h4000, 3, 0, 5);

    // T5: reset during beat-2 strobe of a 4-beat write
    write_burst(16'h1230, 3, -1, 0, 2, -1);

    // T6: back-to-back single reads with REQ_VALID held high
    a = 16'h2345;
    got_q.delete();
    rd_ready = 1'b1;
    acc = 0;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_len   = '0;
    while ((acc < 2 || got_q.size() < 2) && n < 200) begin
      if (rd_valid) got_q.push_back(rd_data);
      if (req_valid && req_ready) acc++;
      @(negedge clk);
      n++;
      if (acc == 2) req_valid = 1'b0;
      if (busy) chk("t6_req_ready_busy", {31'd0, req_ready}, 0);
    end
    rd_ready = 1'b0;
    chk("t6_accepts", acc, 2);
    chk("t6_beats", got_q.size(), 2);
    for (int i = 0; i < got_q.size() && i < 2; i++) chk("t6_data", {24'd0, got_q[i]},
                                                        {24'd0, ref_mem[a]});
    wait_idle("t6_idle");

    // Randomized mix of bursts
    for (int k = 0; k < 14; k++) begin
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                        : 16'($urandom);
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) write_burst(a, len, -1, 0, -1, -1);
      else read_burst(a, len, -1, 0);
      if (k % 3 == 0) read_burst(a, len, -1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
